// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
package stopwatch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUNNING = 3'd1,
      ST_PAUSED  = 3'd2,
      ST_LAP     = 3'd3,
      ST_ALARM   = 3'd4
   } state_t;

   localparam int DEBOUNCE_SAMPLES_DEF = 20;
   localparam int NUM_STATES           = 5;

endpackage

// File: rtl/btn_debouncer.sv
// Button conditioner: 2-flop synchronizer, strobe-driven debounce counter and a
// one-cycle press pulse on each accepted rising level.
module btn_debouncer
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   input  logic sample_en,
   output logic press
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_SAMPLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_SAMPLES - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             level;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         level   <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         // synchronizer stage boundary
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
         press   <= 1'b0;
         if (sample_en) begin
            // the Nth consecutive differing sample flips the level; only 0->1 pulses
            if (sync_p1 == level) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               cnt   <= '0;
               level <= sync_p1;
               press <= sync_p1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch control FSM: debounced buttons sequence IDLE/RUNNING/PAUSED/LAP/ALARM.
// Macro STOPWATCH_LAP_EN enables the lap button, LAP state and display_hold.
module stopwatch_ctrl_fsm
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_SAMPLES = DEBOUNCE_SAMPLES_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_start_pause,
   input  logic       btn_reset,
   input  logic       btn_lap,
   input  logic       sample_en,
   input  logic       blink_en,
   input  logic       max_time_reached,
   output logic       timer_run_en,
   output logic       timer_reset_cmd,
   output logic       display_hold,
   output logic       alarm_led,
   output logic [2:0] state_out
);

   logic   start_press;
   logic   reset_press;
   logic   lap_press;
   state_t state;
   state_t state_nxt;

   btn_debouncer #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_start (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn       (btn_start_pause),
      .sample_en (sample_en),
      .press     (start_press)
   );

   btn_debouncer #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_reset (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn       (btn_reset),
      .sample_en (sample_en),
      .press     (reset_press)
   );

`ifdef STOPWATCH_LAP_EN
   btn_debouncer #(.DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)) u_lap (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn       (btn_lap),
      .sample_en (sample_en),
      .press     (lap_press)
   );
`else
   logic lap_unused;
   assign lap_unused = btn_lap;
   assign lap_press  = 1'b0;
`endif

   // Priority reset > max > start > lap; max only matters while the counter runs.
   function automatic state_t next_state(input state_t cur, input logic rst_p,
                                         input logic max_hit, input logic start_p,
                                         input logic lap_p);
      state_t nxt;
      nxt = cur;
      case (cur)
         ST_IDLE:    nxt = (!rst_p && start_p) ? ST_RUNNING : ST_IDLE;
         ST_RUNNING: begin
            if      (rst_p)   nxt = ST_IDLE;
            else if (max_hit) nxt = ST_ALARM;
            else if (start_p) nxt = ST_PAUSED;
            else if (lap_p)   nxt = ST_LAP;
         end
         ST_LAP: begin
            if      (rst_p)   nxt = ST_IDLE;
            else if (max_hit) nxt = ST_ALARM;
            else if (start_p) nxt = ST_PAUSED;
            else if (lap_p)   nxt = ST_RUNNING;
         end
         ST_PAUSED: begin
            if      (rst_p)   nxt = ST_IDLE;
            else if (start_p) nxt = ST_RUNNING;
         end
         ST_ALARM:   nxt = rst_p ? ST_IDLE : ST_ALARM;
         default:    nxt = ST_IDLE;
      endcase
      return nxt;
   endfunction

   assign state_nxt = next_state(state, reset_press, max_time_reached, start_press, lap_press);
   assign state_out = state;

   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         timer_run_en    <= 1'b0;
         timer_reset_cmd <= 1'b0;
         display_hold    <= 1'b0;
         alarm_led       <= 1'b0;
      end else begin
         state           <= state_nxt;
         timer_run_en    <= (state_nxt == ST_RUNNING) || (state_nxt == ST_LAP);
         timer_reset_cmd <= reset_press;
`ifdef STOPWATCH_LAP_EN
         display_hold    <= (state_nxt == ST_LAP);
`else
         display_hold    <= 1'b0;
`endif
         if (state_nxt != ST_ALARM) begin
            alarm_led <= 1'b0;
         end else if (state != ST_ALARM) begin
            alarm_led <= 1'b1;
         end else if (blink_en) begin
            alarm_led <= ~alarm_led;
         end
      end
   end

endmodule
